rf_wb_scoreboard: RTL
=====================

Name: rf_wb_scoreboard

Overview:
- Controller for the register file (rf) write port and register hazards in the pipeline.
- Round-robin arbitration of NUM_WB writeback requesters onto the single rf write port, through one registered output stage.
- Per-register busy scoreboard: set on instruction issue, cleared when the rf write lands.
- Stalls issue on RAW and WAW hazards; sits between the issue stage, the execute/load units and rf.

Parameters:
- NUM_REGS, 32, architectural register count; index width RW = $clog2(NUM_REGS).
- NUM_WB, 2, number of writeback requesters (0 = ALU, 1 = load unit); must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_rs1, issue_rs2  in  RW each  source register indices.
- issue_rd  in  RW  destination index.
- issue_wr  in  1  instruction writes issue_rd.
- issue_stall  out  1  hazard; instruction must not issue this cycle.
- wb_valid  in  NUM_WB  per-requester writeback request.
- wb_rd  in  NUM_WB x RW  per-requester destination index.
- wb_data  in  NUM_WB x data_t  per-requester write data.
- wb_ready  out  NUM_WB  one-hot grant; the request is accepted this cycle.
- rf_we  out  1  rf write enable, registered.
- rf_rd  out  RW  rf write index, registered.
- rf_wr_data  out  data_t  rf write data, registered.
- busy  out  NUM_REGS  scoreboard vector, for debug and forwarding.

Behaviour:
- Reset values:
  - busy = 0; rf_we = 0; rf_rd = 0; rf_wr_data = 0.
  - Round-robin pointer last = NUM_WB-1, so requester 0 has highest priority first.
  - Reset asserted mid-operation discards any pending output-stage write and all busy bits on the same edge.
- Arbitration (combinational, same cycle):
  - Search wb_valid starting at (last+1) mod NUM_WB, wrapping; first valid wins.
  - wb_ready = one-hot of the winner; all zero when no wb_valid.
  - wb_ready never asserts for a requester with wb_valid low.
  - last updates to the winner only on cycles with a grant.
  - Requesters hold wb_valid, wb_rd and wb_data stable until granted.
- Output stage:
  - On a grant in cycle N: rf_we = 1, rf_rd = wb_rd[winner], rf_wr_data = wb_data[winner] during cycle N+1.
  - rf captures the write at the end of N+1; latency is 1 cycle from grant to rf write.
  - No grant in N gives rf_we = 0 in N+1; rf_rd and rf_wr_data hold their previous values.
  - Winner rd = 0: the grant is still given (requester drains), but rf_we stays 0 and x0 is never written.
- Scoreboard:
  - set_vec: bit issue_rd set when issue_valid & !issue_stall & issue_wr & issue_rd != 0.
  - clr_vec: bit rf_rd set when rf_we.
  - busy_next = (busy & ~clr_vec) | set_vec; a set wins when set and clear hit the same index in the same cycle.
  - Writeback to a non-busy register still performs the rf write; the busy bit stays 0.
- Hazard:
  - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_wr & busy[rd])).
  - Computed from the current registered busy only; there is no same-cycle bypass of clr_vec.
  - A consumer therefore issues the cycle after the rf write edge, when rf reads return the new value.
  - busy[0] is always 0, so index 0 never stalls.
  - issue_stall = 0 when issue_valid = 0.
- Other: issue and writeback are independent; both may occur in the same cycle.

Decomposition:
- Shared package (defines.sv):
  - data_t, 32-bit.
  - NUM_REGS default; reg_idx_t typedef of width RW.
- Sub-module rr_arbiter #(N): inputs req and advance; outputs one-hot gnt; holds the pointer state internally.
  - Reused later for memory-port sharing.
- Scoreboard and output stage live in the top module.

Test Plan:
- Reset, then idle for 5 cycles -> busy = 0, rf_we = 0, wb_ready = 00, issue_stall = 0.
- Issue rd=5 (issue_wr=1); next cycle issue rs1=5 -> busy[5]=1 and stall asserts.
  - Requester 0 then sends rd=5, data=0xDEADBEEF and is granted in cycle N.
  - Cycle N+1: rf_we=1, rf_rd=5, rf_wr_data=0xDEADBEEF; stall stays high.
  - Cycle N+2: busy[5]=0, stall drops; rf read of x5 returns 0xDEADBEEF.
- Both requesters hold wb_valid for 4 cycles, each re-asserting after its grant -> wb_ready sequence 01, 10, 01, 10.
  - rf_rd follows each request with a one-cycle lag.
- Requester 1 sends rd=0, data=0x1234 -> wb_ready=10, rf_we stays 0, x0 reads 0.
- Same cycle: rf_we clears busy[7] and a new issue sets rd=7 -> busy[7]=1 afterwards.
  - Also: issue with rs1=7 while busy[7]=1 -> stall; issue with rd=7 while busy[7]=1 -> WAW stall.
- Grant in cycle N, reset asserted in N+1 -> rf_we=0 from N+2 onward, busy=0.
  - Next grant goes to requester 0 when both requesters are valid.

Source files
------------

// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared types for the register-file writeback path and hazard scoreboard.
package rf_wb_scoreboard_pkg;

    localparam int unsigned DataWidth = 32;
    typedef logic [DataWidth-1:0] data_t;

    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned RW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);
    typedef logic [RW_DEFAULT-1:0] reg_idx_t;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PW = idx_width(N);

    logic [PW-1:0] last_q, last_d;

    always_comb begin
        logic        found;
        int unsigned idx;
        gnt_o  = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                last_d     = PW'(idx);
            end
        end
    end

    // Reset pointer to the top entry so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PW'(N - 1);
        end else if (advance_i && (|gnt_o)) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port arbiter, registered write stage and busy scoreboard
// that stalls issue on RAW/WAW hazards.
module rf_wb_scoreboard
    import rf_wb_scoreboard_pkg::*;
#(
    parameter  int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter  int unsigned NUM_WB   = 2,
    localparam int unsigned RW       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid_i,
    input  logic [RW-1:0]                  issue_rs1_i,
    input  logic [RW-1:0]                  issue_rs2_i,
    input  logic [RW-1:0]                  issue_rd_i,
    input  logic                           issue_wr_i,
    output logic                           issue_stall_o,
    input  logic [NUM_WB-1:0]              wb_valid_i,
    input  logic [NUM_WB-1:0][RW-1:0]      wb_rd_i,
    input  data_t [NUM_WB-1:0]             wb_data_i,
    output logic [NUM_WB-1:0]              wb_ready_o,
    output logic                           rf_we_o,
    output logic [RW-1:0]                  rf_rd_o,
    output data_t                          rf_wr_data_o,
    output logic [NUM_REGS-1:0]            busy_o
);

    logic [NUM_WB-1:0]   gnt;
    logic                grant;
    logic [RW-1:0]       win_rd;
    data_t               win_data;

    logic                rf_we_q, rf_we_d;
    logic [RW-1:0]       rf_rd_q, rf_rd_d;
    data_t               rf_data_q, rf_data_d;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec;

    rr_arbiter #(
        .N (NUM_WB)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (wb_valid_i),
        .advance_i (|wb_valid_i),
        .gnt_o     (gnt)
    );

    assign grant      = |gnt;
    assign wb_ready_o = gnt;

    // Grant is one-hot, so an OR-mux selects the winner.
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (gnt[i]) begin
                win_rd   = win_rd | wb_rd_i[i];
                win_data = win_data | wb_data_i[i];
            end
        end
    end

    // x0 writebacks drain through the grant but never reach the rf.
    always_comb begin
        rf_we_d   = grant && (win_rd != '0);
        rf_rd_d   = rf_we_d ? win_rd : rf_rd_q;
        rf_data_d = rf_we_d ? win_data : rf_data_q;
    end

    assign issue_stall_o = issue_valid_i &
                           (busy_q[issue_rs1_i] | busy_q[issue_rs2_i] |
                            (issue_wr_i & busy_q[issue_rd_i]));

    // Clear first, then set, so a same-cycle issue keeps the register busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid_i && !issue_stall_o && issue_wr_i && (issue_rd_i != '0)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        if (rf_we_q) begin
            clr_vec[rf_rd_q] = 1'b1;
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_rd_o      = rf_rd_q;
    assign rf_wr_data_o = rf_data_q;
    assign busy_o       = busy_q;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_gnt_valid  : assert property (@(posedge clk) disable iff (reset)
                                    (gnt & ~wb_valid_i) == '0);
    a_x0_idle    : assert property (@(posedge clk) disable iff (reset) !busy_q[0]);

endmodule
